bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter BLANK_CODE, default 4'hF, SHALL be the digit code driven for a blanked leading zero.
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 start  input  1  SHALL request a conversion of data_in; sampled only in IDLE.
REQ-005 data_in  input  16  SHALL be the signed two's-complement sample (accelerometer axis) to convert.
REQ-006 busy  output  1  SHALL be high while a conversion is in progress.
REQ-007 done  output  1  SHALL be a one-cycle pulse marking new valid digits.
REQ-008 neg  output  1  SHALL be the sign of the last converted sample (1 = negative).
REQ-009 bcd4..bcd0  output  4 each  SHALL be the decimal digits of |data_in| (bcd4 = ten-thousands, bcd0 = ones), feeding the per-digit 7-segment decoders.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT and DONE, encoded in a registered state variable.
REQ-011 IDLE with start=1 at a rising edge SHALL latch neg = data_in[15] and magnitude = data_in[15] ? -data_in : data_in (16-bit unsigned, so 16'h8000 -> 32768), clear the 20-bit BCD scratch and the 4-bit iteration counter, and enter SHIFT.
REQ-012 Each SHIFT cycle SHALL perform one double-dabble step: add 3 to every scratch nibble >= 5, then shift {scratch, magnitude} left by one and increment the counter.
REQ-013 After the 16th shift, the FSM SHALL enter DONE; DONE SHALL register the scratch digits into bcd4..bcd0, register neg, pulse done=1 for exactly one cycle, and return to IDLE.
REQ-014 Latency SHALL be fixed: done is high in the 17th cycle after the edge that accepted start; busy is high in SHIFT, low in IDLE and DONE.
REQ-015 start SHALL be ignored in SHIFT and DONE; data_in changes after acceptance SHALL NOT affect the result.
REQ-016 start held high continuously SHALL produce one conversion every 18 cycles (accept, 16 SHIFT, DONE).
REQ-017 bcd4..bcd0 and neg SHALL hold their last values between done pulses.
REQ-018 Input 0 SHALL give neg=0 and all digits 0; neg SHALL be 0 for any non-negative input.
REQ-019 Every output digit SHALL be in 0..9 or equal to BLANK_CODE; no other code is legal.

Reset
REQ-020 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, neg=0, bcd4..bcd0=0, scratch and counter cleared.
REQ-021 Reset asserted mid-conversion SHALL abort it with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-022 Macro LEAD_ZERO_BLANK_EN defined: in DONE, each zero digit above the most significant non-zero digit SHALL be replaced by BLANK_CODE; bcd0 SHALL never be blanked.
REQ-023 Macro LEAD_ZERO_BLANK_EN undefined: all five digits SHALL be output as raw BCD, with no blanking logic present.

Verification
REQ-024 data_in=16'd1234, start pulse -> done 17 cycles later; bcd4..0 = 0,1,2,3,4 (blank: F,1,2,3,4), neg=0.
REQ-025 data_in=16'hFF00 (-256) -> bcd4..0 = 0,0,2,5,6 (blank: F,F,2,5,6), neg=1.
REQ-026 data_in=16'h8000 -> bcd4..0 = 3,2,7,6,8, neg=1; data_in=16'h7FFF -> 3,2,7,6,7, neg=0.
REQ-027 data_in=0 -> all digits 0 (blank: F,F,F,F,0), neg=0.
REQ-028 start with 16'd99, then start with 16'd500 at cycle 5 of SHIFT -> only 99 reported (0,0,0,9,9); rst_n low at cycle 8 of a later conversion -> busy=0, no done, all outputs 0.
REQ-029 start held high, data_in=16'd42 -> done pulses every 18 cycles, digits stable at 0,0,0,4,2.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: signed 16-bit sample -> sign + five BCD digits.
// Optional leading-zero blanking is enabled by defining LEAD_ZERO_BLANK_EN.
module bin2bcd_seq #(
   parameter logic [3:0] BLANK_CODE = 4'hF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] data_in,
   output logic        busy,
   output logic        done,
   output logic        neg,
   output logic [3:0]  bcd4,
   output logic [3:0]  bcd3,
   output logic [3:0]  bcd2,
   output logic [3:0]  bcd1,
   output logic [3:0]  bcd0
);

   // state | meaning
   // IDLE  | waiting for start; outputs hold the last result
   // SHIFT | one double-dabble step per cycle, 16 cycles
   // DONE  | done pulse with the new digits, then back to IDLE
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_mag;
   logic [19:0] r_scratch;
   logic [3:0]  r_cnt;
   logic        r_neg_lat;
   logic        r_done;
   logic        r_neg;
   logic [19:0] r_bcd;
   logic [19:0] w_adj;
   logic [19:0] w_scratch_nxt;
   logic [15:0] w_mag_nxt;
   logic [19:0] w_digits;
   logic        w_last;

   always_comb begin
      w_adj = r_scratch;
      for (int i = 0; i < 5; i++) begin
         if (r_scratch[4*i +: 4] >= 4'd5)
            w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
   end

   assign {w_scratch_nxt, w_mag_nxt} = {w_adj, r_mag} << 1;
   assign w_last = (r_state == SHIFT) && (r_cnt == 4'd15);

`ifdef LEAD_ZERO_BLANK_EN
   logic w_lead;

   // Blank zeros above the most significant non-zero digit; ones digit always shown.
   always_comb begin
      w_digits = w_scratch_nxt;
      w_lead   = 1'b1;
      for (int i = 4; i >= 1; i--) begin
         if (w_lead && (w_scratch_nxt[4*i +: 4] == 4'd0))
            w_digits[4*i +: 4] = BLANK_CODE;
         else
            w_lead = 1'b0;
      end
   end
`else
   assign w_digits = w_scratch_nxt;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = SHIFT;
         SHIFT:   if (r_cnt == 4'd15) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Results are loaded on the edge into DONE so digits are valid alongside the done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mag     <= '0;
         r_scratch <= '0;
         r_cnt     <= '0;
         r_neg_lat <= 1'b0;
         r_done    <= 1'b0;
         r_neg     <= 1'b0;
         r_bcd     <= '0;
      end else begin
         r_done <= w_last;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_neg_lat <= data_in[15];
                  r_mag     <= data_in[15] ? (~data_in + 16'd1) : data_in;
                  r_scratch <= '0;
                  r_cnt     <= '0;
               end
            end
            SHIFT: begin
               r_scratch <= w_scratch_nxt;
               r_mag     <= w_mag_nxt;
               r_cnt     <= r_cnt + 4'd1;
               if (w_last) begin
                  r_bcd <= w_digits;
                  r_neg <= r_neg_lat;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state == SHIFT);
   assign done = r_done;
   assign neg  = r_neg;
   assign {bcd4, bcd3, bcd2, bcd1, bcd0} = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: arithmetic reference model checked every cycle plus directed vectors.
module tb_bin2bcd_seq;

   localparam logic [3:0] BLANK = 4'hF;
`ifdef LEAD_ZERO_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [15:0] data_in = '0;
   logic        busy, done, neg;
   logic [3:0]  bcd4, bcd3, bcd2, bcd1, bcd0;

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   bin2bcd_seq #(.BLANK_CODE(BLANK)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
      .busy(busy), .done(done), .neg(neg),
      .bcd4(bcd4), .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Decimal digits of |v| by plain division, with optional leading-zero blanking.
   function automatic logic [19:0] exp_digits(input logic [15:0] v);
      int m;
      logic [3:0] d[5];
      bit lead;
      m = v[15] ? (65536 - int'(v)) : int'(v);
      for (int k = 0; k < 5; k++) begin
         d[k] = 4'(m % 10);
         m = m / 10;
      end
      lead = 1'b1;
      for (int k = 4; k >= 1; k--) begin
         if (BLANK_ON && lead && d[k] == 4'd0) d[k] = BLANK;
         else lead = 1'b0;
      end
      return {d[4], d[3], d[2], d[1], d[0]};
   endfunction

   // Cycle model: phase 0 idle, 1..16 converting, 17 result cycle.
   int          m_phase = 0;
   logic [15:0] m_val   = '0;
   logic [19:0] e_dig   = '0;
   logic        e_neg   = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0;
         e_dig   = '0;
         e_neg   = 1'b0;
      end else if (m_phase == 0) begin
         if (start) begin
            m_phase = 1;
            m_val   = data_in;
         end
      end else if (m_phase < 17) begin
         m_phase++;
         if (m_phase == 17) begin
            e_dig = exp_digits(m_val);
            e_neg = m_val[15];
         end
      end else begin
         m_phase = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, (m_phase >= 1 && m_phase <= 16));
         chk("done", done, (m_phase == 17));
         chk("neg", neg, e_neg);
         chk("digits", {bcd4, bcd3, bcd2, bcd1, bcd0}, e_dig);
         chk("digit_legal",
             ((bcd4 <= 9 || bcd4 == BLANK) && (bcd3 <= 9 || bcd3 == BLANK) &&
              (bcd2 <= 9 || bcd2 == BLANK) && (bcd1 <= 9 || bcd1 == BLANK) &&
              (bcd0 <= 9 || bcd0 == BLANK)), 1);
      end
   end

   task automatic convert(input logic [15:0] val, input logic [19:0] e_raw,
                          input logic [19:0] e_blk, input logic eneg, input int poke);
      int cyc;
      @(negedge clk);
      start   = 1'b1;
      data_in = val;
      @(negedge clk);
      start   = 1'b0;
      data_in = 16'($urandom);
      cyc = 1;
      while (!done && cyc < 40) begin
         if (cyc == poke) begin
            start   = 1'b1;
            data_in = 16'd500;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk("latency", cyc, 17);
      chk("vec_digits", {bcd4, bcd3, bcd2, bcd1, bcd0}, BLANK_ON ? e_blk : e_raw);
      chk("vec_neg", neg, eneg);
   endtask

   initial begin
      int last_done;
      int n_done;
      int cyc;

      chk("model_1234", exp_digits(16'd1234), BLANK_ON ? 20'hF1234 : 20'h01234);
      chk("model_m256", exp_digits(16'hFF00), BLANK_ON ? 20'hFF256 : 20'h00256);
      chk("model_8000", exp_digits(16'h8000), 20'h32768);
      chk("model_zero", exp_digits(16'h0000), BLANK_ON ? 20'hFFFF0 : 20'h00000);

      #3 rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_neg", neg, 0);
      chk("rst_digits", {bcd4, bcd3, bcd2, bcd1, bcd0}, 0);
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;

      convert(16'd1234, 20'h01234, 20'hF1234, 1'b0, -1);
      convert(16'hFF00, 20'h00256, 20'hFF256, 1'b1, -1);
      convert(16'h8000, 20'h32768, 20'h32768, 1'b1, -1);
      convert(16'h7FFF, 20'h32767, 20'h32767, 1'b0, -1);
      convert(16'd0,    20'h00000, 20'hFFFF0, 1'b0, -1);
      convert(16'd99,   20'h00099, 20'hFFF99, 1'b0, 5);
      repeat (2) @(negedge clk);
      chk("hold_digits", {bcd4, bcd3, bcd2, bcd1, bcd0}, BLANK_ON ? 20'hFFF99 : 20'h00099);

      // Abort a conversion with reset in its eighth cycle.
      @(negedge clk);
      start   = 1'b1;
      data_in = 16'hF000;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_neg", neg, 0);
      chk("abort_digits", {bcd4, bcd3, bcd2, bcd1, bcd0}, 0);
      repeat (12) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
      end
      #1 rst_n = 1'b1;
      convert(16'd1234, 20'h01234, 20'hF1234, 1'b0, -1);

      // Start held high: one result every 18 cycles.
      @(negedge clk);
      start   = 1'b1;
      data_in = 16'd42;
      n_done = 0;
      last_done = 0;
      cyc = 0;
      while (n_done < 3 && cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            chk("cont_digits", {bcd4, bcd3, bcd2, bcd1, bcd0}, BLANK_ON ? 20'hFFF42 : 20'h00042);
            if (n_done > 0) chk("cont_period", cyc - last_done, 18);
            last_done = cyc;
            n_done++;
         end
      end
      chk("cont_count", n_done, 3);
      start = 1'b0;
      repeat (20) @(negedge clk);
      chk("final_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
